// File: rtl/audio_synth.sv
// Sequenced square-wave tone generator: a 16-step note ROM drives a phase
// accumulator whose MSB selects +/- half-envelope around the 8'h80 midpoint.
module audio_synth #(
    parameter int SAMPLE_DIV   = 256,
    parameter int STEP_SAMPLES = 6144,
    parameter int ENV_DIV      = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [3:0] step_idx
);

    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int SW = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam int EW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_SAMPLES - 1);
    localparam logic [EW-1:0] ENV_LAST  = EW'(ENV_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [15:0]   phase;
    logic [SW-1:0] sample_cnt;
    logic [EW-1:0] env_cnt;
    logic [7:0]    env;

    logic          tick;
    logic          step_end;
    logic [15:0]   inc;
    logic [15:0]   phase_n;
    logic [7:0]    half;
    logic [7:0]    sample_n;
    logic [3:0]    next_idx;
    logic [15:0]   next_inc;

    // Phase increment per sequencer step; zero entries are rests.
    function automatic logic [15:0] note_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    note_rom = 16'd293;
            4'd2:    note_rom = 16'd329;
            4'd4:    note_rom = 16'd369;
            4'd6:    note_rom = 16'd391;
            4'd8:    note_rom = 16'd439;
            4'd10:   note_rom = 16'd391;
            4'd12:   note_rom = 16'd369;
            4'd14:   note_rom = 16'd329;
            default: note_rom = 16'd0;
        endcase
    endfunction

    always_comb begin
        tick     = enable && (div_cnt == DIV_LAST);
        step_end = (sample_cnt == STEP_LAST);
        inc      = note_rom(step_idx);
        phase_n  = phase + inc;
        half     = {1'b0, env[7:1]};
        sample_n = phase_n[15] ? (8'h80 + half) : (8'h80 - half);
        next_idx = step_idx + 4'd1;
        next_inc = note_rom(next_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            phase        <= 16'h0000;
            sample_cnt   <= '0;
            env_cnt      <= '0;
            env          <= 8'hFF;
            step_idx     <= 4'd0;
            sample       <= 8'h80;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            sample       <= 8'h80;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick;
            div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            if (tick) begin
                // Emitted sample always reflects the step that is ending.
                sample <= sample_n;
                if (step_end) begin
                    sample_cnt <= '0;
                    step_idx   <= next_idx;
                    phase      <= 16'h0000;
                    env_cnt    <= '0;
                    env        <= (next_inc != 16'd0) ? 8'hFF : 8'h00;
                end else begin
                    phase      <= phase_n;
                    sample_cnt <= sample_cnt + SW'(1);
                    if (env_cnt == ENV_LAST) begin
                        env_cnt <= '0;
                        env     <= (env != 8'h00) ? env - 8'h01 : 8'h00;
                    end else begin
                        env_cnt <= env_cnt + EW'(1);
                    end
                end
            end
        end
    end

endmodule
